// File: rtl/cmd_ser_tx.sv
// Byte-serial command transmitter: 2-entry {addr,data} request FIFO feeding a packet serializer.
// Optional macro CMD_SER_TX_GAP_EN inserts one idle GAP cycle after every packet.
module cmd_ser_tx #(
    parameter int NUM_CYCLES = 6
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] data,
    output logic        ready,
    output logic [7:0]  cmd_ad,
    output logic        cmd_stb,
    output logic        busy,
    output logic        ovf
);

`ifdef CMD_SER_TX_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

    localparam logic [2:0] LAST = 3'(NUM_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [47:0]       pkt_q, pkt_d;
    logic [1:0][47:0]  mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [7:0]        cmd_ad_q, cmd_ad_d;
    logic              cmd_stb_q, cmd_stb_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;
    logic [47:0]       head;

    assign ready   = (count_q != 2'd2);
    assign cmd_ad  = cmd_ad_q;
    assign cmd_stb = cmd_stb_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;
    assign head    = mem_q[rd_ptr_q];
    // Acceptance is judged by this cycle's ready; a same-cycle pop never frees room.
    assign push    = we & ready;

    // State register (all flops)
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pkt_q     <= '0;
            mem_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            cmd_ad_q  <= '0;
            cmd_stb_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cmd_ad_q  <= cmd_ad_d;
            cmd_stb_q <= cmd_stb_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic; pop marks the start of a packet
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    pop     = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == LAST) begin
`ifdef CMD_SER_TX_GAP_EN
                    state_d = GAP;
`else
                    if (count_q != 2'd0) begin
                        cnt_d = '0;
                        pop   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`ifdef CMD_SER_TX_GAP_EN
            GAP: begin
                if (count_q != 2'd0) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {data, addr};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        pkt_d     = pop ? head : pkt_q;
        cmd_stb_d = pop;
        // {data,addr} packing makes byte i simply bits [8i +: 8]
        cmd_ad_d  = (state_d == SEND) ? pkt_d[{cnt_d, 3'b000} +: 8] : 8'h00;
        busy_d    = (state_d != IDLE) || (count_d != 2'd0);
        ovf_d     = ovf_q | (we & ~ready);
    end

endmodule

// File: tb/tb_cmd_ser_tx.sv
// Randomized bench for cmd_ser_tx: two instances (NUM_CYCLES 6 and 3) checked against a queue-based model.
module tb_cmd_ser_tx;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        we   = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] data = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NC = (g == 0) ? 6 : 3;

        logic       ready, cmd_stb, busy, ovf;
        logic [7:0] cmd_ad;

        cmd_ser_tx #(.NUM_CYCLES(NC)) u_dut (
            .mclk(mclk), .rst(rst), .we(we), .addr(addr), .data(data),
            .ready(ready), .cmd_ad(cmd_ad), .cmd_stb(cmd_stb), .busy(busy), .ovf(ovf)
        );

        // Model: pending requests, plus the scheduled output stream {active, stb, byte}
        logic [47:0] pend[$];
        logic [9:0]  expq[$];
        logic        m_ovf, m_stb, m_busy, m_ready;
        logic [7:0]  m_ad;

        always begin
            logic [47:0] w;
            logic [9:0]  e;
            logic        acc;
            @(posedge mclk);
            if (rst) begin
                pend.delete();
                expq.delete();
                m_ovf  = 1'b0;
                m_ad   = 8'h00;
                m_stb  = 1'b0;
                m_busy = 1'b0;
            end else begin
                acc = we && (pend.size() < 2);
                if (we && !acc) m_ovf = 1'b1;
                if (expq.size() == 0 && pend.size() > 0) begin
                    w = pend.pop_front();
                    for (int k = 0; k < NC; k++) expq.push_back({1'b1, (k == 0), w[8*k +: 8]});
`ifdef CMD_SER_TX_GAP_EN
                    expq.push_back(10'b10_0000_0000);
`endif
                end
                e = (expq.size() > 0) ? expq.pop_front() : 10'd0;
                if (acc) pend.push_back({data, addr});
                m_ad   = e[7:0];
                m_stb  = e[8];
                m_busy = e[9] || (expq.size() > 0) || (pend.size() > 0);
            end
            m_ready = (pend.size() < 2);
            #1;
            chk($sformatf("nc%0d_cmd_ad", NC),  32'(cmd_ad),  32'(m_ad));
            chk($sformatf("nc%0d_cmd_stb", NC), 32'(cmd_stb), 32'(m_stb));
            chk($sformatf("nc%0d_busy", NC),    32'(busy),    32'(m_busy));
            chk($sformatf("nc%0d_ready", NC),   32'(ready),   32'(m_ready));
            chk($sformatf("nc%0d_ovf", NC),     32'(ovf),     32'(m_ovf));
        end
    end

    task automatic tick(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        rst  = r;
        we   = w;
        addr = a;
        data = d;
        @(posedge mclk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic rnd_we();
        tick(1'b0, 1'b1, 16'($urandom), $urandom);
    endtask

    initial begin
        tick(1'b1, 1'b0, 16'h0, 32'h0);
        tick(1'b1, 1'b1, 16'hFFFF, 32'hFFFFFFFF);
        idle(2);
        // Single packet with known bytes
        tick(1'b0, 1'b1, 16'h1234, 32'hAABBCCDD);
        idle(10);
        tick(1'b0, 1'b1, 16'h0102, 32'h00000055);
        idle(10);
        // Three back-to-back requests
        repeat (3) rnd_we();
        idle(24);
        // Four back-to-back: the fourth overflows
        repeat (4) rnd_we();
        idle(26);
        // Reset while the third byte is on the bus with one entry pending
        rnd_we();
        rnd_we();
        idle(2);
        tick(1'b1, 1'b1, 16'h5A5A, 32'h5A5A5A5A);
        idle(8);
        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0)
                tick(1'b1, 1'($urandom), 16'($urandom), $urandom);
            else if ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 15))
                rnd_we();
            else
                idle(1);
        end
        idle(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
